// File: rtl/ifetch_unit_pkg.sv
// Shared types, opcode constants and immediate decoders for the fetch stage.
package ifetch_unit_pkg;
  localparam int unsigned ADDR_WID = 32;
  localparam int unsigned INST_WID = 32;

  localparam logic [6:0] OPCODE_JAL  = 7'b1101111;
  localparam logic [6:0] OPCODE_B    = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR = 7'b1100111;

  typedef struct packed {
    logic [INST_WID-1:0] inst;
    logic [ADDR_WID-1:0] pc;
    logic                pred_taken;
  } fq_entry_t;

  function automatic logic [ADDR_WID-1:0] j_imm(input logic [INST_WID-1:0] i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic [ADDR_WID-1:0] b_imm(input logic [INST_WID-1:0] i);
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction
endpackage

// File: rtl/ifetch_unit_if.sv
// Refill, fetch-output, redirect and branch-update signals of the fetch stage.
interface ifetch_unit_if
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned LINE_INSTS = 16
) ();
  logic                           rollback;
  logic [ADDR_WID-1:0]            rollback_pc;
  logic                           icache_flush;
  logic                           mem_en;
  logic [ADDR_WID-1:0]            mem_pc;
  logic                           mem_done;
  logic [LINE_INSTS*INST_WID-1:0] mem_data;
  logic                           inst_valid;
  logic                           inst_ready;
  logic [INST_WID-1:0]            inst;
  logic [ADDR_WID-1:0]            inst_pc;
  logic                           inst_pred_taken;
  logic                           upd_en;
  logic                           upd_taken;
  logic [ADDR_WID-1:0]            upd_pc;

  modport master (
    input  rollback, rollback_pc, icache_flush, mem_done, mem_data,
           inst_ready, upd_en, upd_taken, upd_pc,
    output mem_en, mem_pc, inst_valid, inst, inst_pc, inst_pred_taken
  );

  modport slave (
    output rollback, rollback_pc, icache_flush, mem_done, mem_data,
           inst_ready, upd_en, upd_taken, upd_pc,
    input  mem_en, mem_pc, inst_valid, inst, inst_pc, inst_pred_taken
  );
endinterface

// File: rtl/ifetch_unit_fetch_queue.sv
// Synchronous FIFO decoupling fetch from decode; flush empties it in one cycle.
module ifetch_unit_fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WID   = 65
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WID-1:0]           din,
  output logic [WID-1:0]           dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WID-1:0]   mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (en) begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
    end
  end

  // Storage needs no reset; only entries behind the write pointer are ever read.
  always_ff @(posedge clk) begin
    if (en && !flush && do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: direct-mapped I-cache, 2-bit BHT predictor, refill FSM and fetch queue.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned   ICACHE_LINES = 16,
  parameter int unsigned   LINE_INSTS   = 16,
  parameter int unsigned   BHT_ENTRIES  = 64,
  parameter int unsigned   FQ_DEPTH     = 4,
  parameter logic [31:0]   RESET_PC     = 32'h0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  ifetch_unit_if.master bus
);
  localparam int unsigned WOFF  = $clog2(LINE_INSTS);
  localparam int unsigned OFF   = WOFF + 2;
  localparam int unsigned IDX   = $clog2(ICACHE_LINES);
  localparam int unsigned TAG   = ADDR_WID - OFF - IDX;
  localparam int unsigned BHT_W = $clog2(BHT_ENTRIES);
  localparam int unsigned FQ_CW = $clog2(FQ_DEPTH) + 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FETCH = 1'b1;

  logic [ADDR_WID-1:0] pc;
  logic [ICACHE_LINES-1:0] valid;
  logic [TAG-1:0]      tags  [ICACHE_LINES];
  logic [INST_WID-1:0] lines [ICACHE_LINES][LINE_INSTS];
  logic [1:0]          bht   [BHT_ENTRIES];

  logic [0:0]          state, state_n;
  logic                mem_en_n, fill_c;
  logic [ADDR_WID-1:0] mem_pc_n;

  logic [IDX-1:0]      pc_idx, fill_idx;
  logic [TAG-1:0]      pc_tag;
  logic [BHT_W-1:0]    bht_idx, upd_idx;
  logic [INST_WID-1:0] word;
  logic                hit, pop, push, pred_taken;
  logic [ADDR_WID-1:0] pred_pc;
  fq_entry_t           fq_in, fq_out;
  logic                fq_full, fq_empty;
  logic [FQ_CW-1:0]    fq_count;

  assign pc_idx   = pc[OFF +: IDX];
  assign pc_tag   = pc[ADDR_WID-1 -: TAG];
  assign fill_idx = bus.mem_pc[OFF +: IDX];
  assign bht_idx  = pc[2 +: BHT_W];
  assign upd_idx  = bus.upd_pc[2 +: BHT_W];
  assign hit      = valid[pc_idx] && (tags[pc_idx] == pc_tag);
  assign word     = lines[pc_idx][pc[2 +: WOFF]];

  // Static JAL, BHT-steered conditional branches, everything else falls through.
  always_comb begin
    pred_taken = 1'b0;
    pred_pc    = pc + 32'd4;
    case (word[6:0])
      OPCODE_JAL: begin
        pred_taken = 1'b1;
        pred_pc    = pc + j_imm(word);
      end
      OPCODE_B: begin
        if (bht[bht_idx][1]) begin
          pred_taken = 1'b1;
          pred_pc    = pc + b_imm(word);
        end
      end
      OPCODE_JALR: ;
      default: ;
    endcase
  end

  assign pop   = bus.inst_valid && bus.inst_ready;
  assign push  = hit && !bus.rollback && !bus.icache_flush && (!fq_full || pop);
  assign fq_in = {word, pc, pred_taken};

  ifetch_unit_fetch_queue #(
    .DEPTH (FQ_DEPTH),
    .WID   ($bits(fq_entry_t))
  ) u_fq (
    .clk   (clk),
    .rst   (rst),
    .en    (rdy),
    .flush (bus.rollback),
    .push  (push),
    .pop   (pop),
    .din   (fq_in),
    .dout  (fq_out),
    .full  (fq_full),
    .empty (fq_empty),
    .count (fq_count)
  );

  assign bus.inst_valid      = (fq_count != '0);
  assign bus.inst            = fq_empty ? '0 : fq_out.inst;
  assign bus.inst_pc         = fq_empty ? '0 : fq_out.pc;
  assign bus.inst_pred_taken = fq_empty ? 1'b0 : fq_out.pred_taken;

  // Refill FSM: a started request always runs to mem_done, even across rollback.
  always_comb begin
    state_n  = state;
    mem_en_n = bus.mem_en;
    mem_pc_n = bus.mem_pc;
    fill_c   = 1'b0;
    case (state)
      IDLE: begin
        if (!hit && !bus.rollback && !bus.icache_flush) begin
          state_n  = FETCH;
          mem_en_n = 1'b1;
          mem_pc_n = {pc[ADDR_WID-1:OFF], {OFF{1'b0}}};
        end
      end
      FETCH: begin
        if (bus.mem_done) begin
          state_n  = IDLE;
          mem_en_n = 1'b0;
          fill_c   = !bus.icache_flush;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bus.mem_en <= 1'b0;
      bus.mem_pc <= '0;
    end else if (rdy) begin
      state      <= state_n;
      bus.mem_en <= mem_en_n;
      bus.mem_pc <= mem_pc_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               pc <= RESET_PC;
    else if (rdy) begin
      if (bus.rollback)    pc <= bus.rollback_pc;
      else if (push)       pc <= pred_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   valid <= '0;
    else if (rdy) begin
      if (bus.icache_flush)    valid <= '0;
      else if (fill_c)         valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && fill_c) begin
      tags[fill_idx] <= bus.mem_pc[ADDR_WID-1 -: TAG];
      for (int k = 0; k < LINE_INSTS; k++)
        lines[fill_idx][k] <= bus.mem_data[INST_WID*k +: INST_WID];
    end
  end

  // Saturating 2-bit counters, weakly not-taken out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (rdy && bus.upd_en) begin
      if (bus.upd_taken && bht[upd_idx] != 2'b11)
        bht[upd_idx] <= bht[upd_idx] + 2'd1;
      else if (!bus.upd_taken && bht[upd_idx] != 2'b00)
        bht[upd_idx] <= bht[upd_idx] - 2'd1;
    end
  end
endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit against a queue/array-based reference model.
module tb_ifetch_unit;
  import ifetch_unit_pkg::*;

  localparam int unsigned ICACHE_LINES = 16;
  localparam int unsigned LINE_INSTS   = 16;
  localparam int unsigned BHT_ENTRIES  = 64;
  localparam int unsigned FQ_DEPTH     = 4;
  localparam int unsigned OFF          = $clog2(LINE_INSTS) + 2;
  localparam int unsigned IDX          = $clog2(ICACHE_LINES);
  localparam int          NCYC         = 6000;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  ifetch_unit_if #(.LINE_INSTS(LINE_INSTS)) bus ();

  ifetch_unit #(
    .ICACHE_LINES (ICACHE_LINES),
    .LINE_INSTS   (LINE_INSTS),
    .BHT_ENTRIES  (BHT_ENTRIES),
    .FQ_DEPTH     (FQ_DEPTH),
    .RESET_PC     (32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc, m_mem_pc;
  bit          m_fetch;
  bit          m_valid [ICACHE_LINES];
  logic [31:0] m_tag   [ICACHE_LINES];
  int          m_bht   [BHT_ENTRIES];
  int          n_pass, n_total;
  int          rprob;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
  endtask

  // Program memory: a deterministic mix of JAL, branches, JALR and ALU ops keyed by address.
  // kind: 0 other, 1 JAL, 2 conditional branch, 3 JALR.
  function automatic void gen(input logic [31:0] a, output logic [31:0] w,
                              output int kind, output logic [31:0] imm);
    logic [31:0] h;
    h = a * 32'h9E3779B1;
    h = h ^ (h >> 15);
    h = h * 32'h85EBCA6B;
    h = h ^ (h >> 13);
    imm = 32'((int'(h[12:5]) - 128) * 4);
    if (h[3:0] < 4'd2) begin
      kind = 1;
      w = {imm[20], imm[10:1], imm[11], imm[19:12], h[20:16], 7'b1101111};
    end else if (h[3:0] < 4'd6) begin
      kind = 2;
      w = {imm[12], imm[10:5], h[24:15], 3'b000, imm[4:1], imm[11], 7'b1100011};
    end else if (h[3:0] == 4'd6) begin
      kind = 3;
      w = {h[31:12], h[24:20], 7'b1100111};
    end else begin
      kind = 0;
      w = {h[31:7], 7'b0010011};
    end
  endfunction

  task automatic compare_outputs();
    bit ev;
    ev = mq.size() > 0;
    check("inst_valid", 32'(bus.inst_valid), 32'(ev));
    check("inst",       bus.inst,    ev ? mq[0].inst : 32'h0);
    check("inst_pc",    bus.inst_pc, ev ? mq[0].pc   : 32'h0);
    check("pred_taken", 32'(bus.inst_pred_taken), ev ? 32'(mq[0].pred) : 32'h0);
    check("mem_en",     32'(bus.mem_en), 32'(m_fetch));
    check("mem_pc",     bus.mem_pc, m_mem_pc);
  endtask

  task automatic drive_random(input int c);
    int tab[4];
    logic [LINE_INSTS*32-1:0] md;
    logic [31:0] w, imm;
    int kind;
    tab = '{0, 40, 80, 100};
    if (c % 64 == 0) rprob = tab[$urandom_range(0, 3)];
    rdy              = $urandom_range(0, 9) != 0;
    bus.inst_ready   = $urandom_range(0, 99) < rprob;
    bus.rollback     = $urandom_range(0, 99) < 3;
    bus.rollback_pc  = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 255)) << 2);
    bus.icache_flush = $urandom_range(0, 99) < 2;
    bus.mem_done     = rdy && m_fetch && ($urandom_range(0, 2) == 0);
    md = '0;
    for (int k = 0; k < LINE_INSTS; k++) begin
      gen(m_mem_pc + 32'(4 * k), w, kind, imm);
      md[32*k +: 32] = w;
    end
    bus.mem_data  = md;
    bus.upd_en    = $urandom_range(0, 99) < 30;
    bus.upd_taken = $urandom_range(0, 2) != 0;
    bus.upd_pc    = $urandom_range(0, 1) ? m_pc : 32'($urandom_range(0, 4095)) << 2;
  endtask

  // Advance the reference by one clock using the inputs currently driven.
  task automatic model_step();
    logic [31:0] w, imm, nxt;
    int kind, li, fi, bi, ui;
    bit hit, pop, pred;
    if (!rdy) return;
    li   = int'((m_pc >> OFF) % ICACHE_LINES);
    hit  = m_valid[li] && (m_tag[li] == (m_pc >> (OFF + IDX)));
    pop  = (mq.size() > 0) && bus.inst_ready;
    gen(m_pc, w, kind, imm);
    bi   = int'((m_pc >> 2) % BHT_ENTRIES);
    pred = (kind == 1) || (kind == 2 && m_bht[bi] >= 2);
    nxt  = pred ? m_pc + imm : m_pc + 32'd4;

    if (!m_fetch) begin
      if (!hit && !bus.rollback && !bus.icache_flush) begin
        m_fetch  = 1;
        m_mem_pc = m_pc - (m_pc % (LINE_INSTS * 4));
      end
    end else if (bus.mem_done) begin
      m_fetch = 0;
      if (!bus.icache_flush) begin
        fi = int'((m_mem_pc >> OFF) % ICACHE_LINES);
        m_valid[fi] = 1;
        m_tag[fi]   = m_mem_pc >> (OFF + IDX);
      end
    end
    if (bus.icache_flush) foreach (m_valid[i]) m_valid[i] = 0;

    if (bus.rollback) begin
      mq.delete();
      m_pc = bus.rollback_pc;
    end else begin
      if (pop) mq.delete(0);
      if (hit && !bus.icache_flush && mq.size() < FQ_DEPTH) begin
        mq.push_back('{inst: w, pc: m_pc, pred: pred});
        m_pc = nxt;
      end
    end

    if (bus.upd_en) begin
      ui = int'((bus.upd_pc >> 2) % BHT_ENTRIES);
      if (bus.upd_taken) m_bht[ui] = (m_bht[ui] < 3) ? m_bht[ui] + 1 : 3;
      else               m_bht[ui] = (m_bht[ui] > 0) ? m_bht[ui] - 1 : 0;
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rprob = 100;
    rst = 1'b1;
    rdy = 1'b0;
    bus.rollback = 1'b0;
    bus.rollback_pc = '0;
    bus.icache_flush = 1'b0;
    bus.mem_done = 1'b0;
    bus.mem_data = '0;
    bus.inst_ready = 1'b0;
    bus.upd_en = 1'b0;
    bus.upd_taken = 1'b0;
    bus.upd_pc = '0;
    m_pc = 32'h0;
    m_mem_pc = 32'h0;
    m_fetch = 0;
    foreach (m_valid[i]) m_valid[i] = 0;
    foreach (m_bht[i]) m_bht[i] = 1;

    repeat (2) @(negedge clk);
    compare_outputs();
    rst = 1'b0;
    drive_random(0);
    model_step();
    for (int c = 1; c < NCYC; c++) begin
      @(negedge clk);
      compare_outputs();
      drive_random(c);
      model_step();
    end
    @(negedge clk);
    compare_outputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
